// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state codes and counter widths.
package alarm_sequencer_pkg;

    localparam int unsigned StateW = 2;
    localparam int unsigned CntW   = 16;
    localparam int unsigned SnzW   = 3;

    typedef enum logic [StateW-1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } state_e;

endpackage

// File: rtl/alarm_sequencer_btn_edge.sv
// Rising-edge detector for a debounced, synchronized button level.
module alarm_sequencer_btn_edge (
    input  logic MCLK,
    input  logic reset_n,
    input  logic level_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= level_i;
        end
    end

    // Combinational so the press acts on the same clock edge that samples it.
    assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm state controller: arms, rings, snoozes and auto-stops the alarm around the
// programmed time, and drives the ringing/blink indications.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned RING_TICKS   = 60,
    parameter int unsigned SNOOZE_TICKS = 540,
    parameter int unsigned MAX_SNOOZES  = 3
) (
    input  logic              MCLK,
    input  logic              reset_n,
    input  logic              alarm_en,
    input  logic [15:0]       cur_time,
    input  logic [15:0]       alarm_time,
    input  logic              min_tick,
    input  logic              sec_tick,
    input  logic              btn_snooze,
    input  logic              btn_stop,
    output logic              ringing,
    output logic              blink,
    output logic              snoozing,
    output logic [SnzW-1:0]   snooze_count,
    output logic [StateW-1:0] state
);

    localparam logic [CntW-1:0] RingLast   = CntW'(RING_TICKS - 1);
    localparam logic [CntW-1:0] SnoozeLoad = CntW'(SNOOZE_TICKS);
    localparam logic [SnzW-1:0] MaxSnz     = SnzW'(MAX_SNOOZES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   ring_cnt_q, ring_cnt_d;
    logic [CntW-1:0]   snz_cnt_q, snz_cnt_d;
    logic [SnzW-1:0]   snz_used_q, snz_used_d;
    logic              blink_q, blink_d;
    logic              ringing_q, snoozing_q;
    logic              snooze_p, stop_p;
    logic              clear;

    alarm_sequencer_btn_edge u_snooze_edge (
        .MCLK    (MCLK),
        .reset_n (reset_n),
        .level_i (btn_snooze),
        .pulse_o (snooze_p)
    );

    alarm_sequencer_btn_edge u_stop_edge (
        .MCLK    (MCLK),
        .reset_n (reset_n),
        .level_i (btn_stop),
        .pulse_o (stop_p)
    );

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        snz_used_d = snz_used_q;
        blink_d    = blink_q;
        clear      = 1'b0;

        if (!alarm_en) begin
            state_d = StIdle;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArmed;
                    clear   = 1'b1;
                end
                StArmed: begin
                    // Only the minute strobe triggers, so a stopped alarm stays quiet
                    // for the rest of the matching minute.
                    if (min_tick && (cur_time == alarm_time)) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                        blink_d    = 1'b0;
                    end
                end
                StRinging: begin
                    if (stop_p) begin
                        state_d = StArmed;
                        clear   = 1'b1;
                    end else if (snooze_p && (snz_used_q < MaxSnz)) begin
                        state_d    = StSnooze;
                        snz_cnt_d  = SnoozeLoad;
                        snz_used_d = snz_used_q + 1'b1;
                        blink_d    = 1'b0;
                    end else if (sec_tick) begin
                        if (ring_cnt_q == RingLast) begin
                            state_d = StArmed;
                            clear   = 1'b1;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                            blink_d    = ~blink_q;
                        end
                    end
                end
                StSnooze: begin
                    if (stop_p) begin
                        state_d = StArmed;
                        clear   = 1'b1;
                    end else if (sec_tick) begin
                        if (snz_cnt_q == CntW'(1)) begin
                            state_d    = StRinging;
                            ring_cnt_d = '0;
                            snz_cnt_d  = '0;
                            blink_d    = 1'b0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 1'b1;
                        end
                    end
                end
            endcase
        end

        if (clear) begin
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
            snz_used_d = '0;
            blink_d    = 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_used_q <= '0;
            blink_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            snz_used_q <= snz_used_d;
            blink_q    <= blink_d;
            ringing_q  <= (state_d == StRinging);
            snoozing_q <= (state_d == StSnooze);
        end
    end

    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign blink        = blink_q;
    assign snooze_count = snz_used_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed and randomized bench for alarm_sequencer against a behavioural model.
module tb_alarm_sequencer;

    localparam int RING   = 4;
    localparam int SNZ    = 3;
    localparam int MAXSNZ = 2;

    logic        MCLK = 1'b0;
    logic        reset_n;
    logic        alarm_en;
    logic [15:0] cur_time;
    logic [15:0] alarm_time;
    logic        min_tick;
    logic        sec_tick;
    logic        btn_snooze;
    logic        btn_stop;
    logic        ringing;
    logic        blink;
    logic        snoozing;
    logic [2:0]  snooze_count;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    // Model: state code, seconds rung so far, seconds of snooze left, snoozes used.
    int m_state;
    int m_rung;
    int m_left;
    int m_used;
    bit m_blink;
    bit m_prev_snz;
    bit m_prev_stop;

    alarm_sequencer #(
        .RING_TICKS   (RING),
        .SNOOZE_TICKS (SNZ),
        .MAX_SNOOZES  (MAXSNZ)
    ) dut (
        .MCLK         (MCLK),
        .reset_n      (reset_n),
        .alarm_en     (alarm_en),
        .cur_time     (cur_time),
        .alarm_time   (alarm_time),
        .min_tick     (min_tick),
        .sec_tick     (sec_tick),
        .btn_snooze   (btn_snooze),
        .btn_stop     (btn_stop),
        .ringing      (ringing),
        .blink        (blink),
        .snoozing     (snoozing),
        .snooze_count (snooze_count),
        .state        (state)
    );

    always #5 MCLK = ~MCLK;

    function automatic void model_reset();
        m_state     = 0;
        m_rung      = 0;
        m_left      = 0;
        m_used      = 0;
        m_blink     = 1'b0;
        m_prev_snz  = 1'b0;
        m_prev_stop = 1'b0;
    endfunction

    function automatic void model_quiet(input int st);
        m_state = st;
        m_rung  = 0;
        m_left  = 0;
        m_used  = 0;
        m_blink = 1'b0;
    endfunction

    function automatic void model_step();
        bit snz_ev;
        bit stop_ev;
        snz_ev      = btn_snooze && !m_prev_snz;
        stop_ev     = btn_stop && !m_prev_stop;
        m_prev_snz  = btn_snooze;
        m_prev_stop = btn_stop;
        if (!alarm_en) begin
            model_quiet(0);
        end else if (m_state == 0) begin
            model_quiet(1);
        end else if (m_state == 1) begin
            if (min_tick && cur_time == alarm_time) begin
                m_state = 2;
                m_rung  = 0;
            end
        end else if (m_state == 2) begin
            if (stop_ev) begin
                model_quiet(1);
            end else if (snz_ev && m_used < MAXSNZ) begin
                m_state = 3;
                m_left  = SNZ;
                m_used  = m_used + 1;
                m_blink = 1'b0;
            end else if (sec_tick) begin
                m_rung = m_rung + 1;
                if (m_rung >= RING) model_quiet(1);
                else m_blink = !m_blink;
            end
        end else begin
            if (stop_ev) begin
                model_quiet(1);
            end else if (sec_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_state = 2;
                    m_rung  = 0;
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        n_vec++;
        assert (state === 2'(m_state)) else begin
            n_err++;
            $error("FAIL %s state: got %0d want %0d", tag, state, m_state);
        end
        n_vec++;
        assert (ringing === (m_state == 2)) else begin
            n_err++;
            $error("FAIL %s ringing: got %b want %b", tag, ringing, m_state == 2);
        end
        n_vec++;
        assert (snoozing === (m_state == 3)) else begin
            n_err++;
            $error("FAIL %s snoozing: got %b want %b", tag, snoozing, m_state == 3);
        end
        n_vec++;
        assert (snooze_count === 3'(m_used)) else begin
            n_err++;
            $error("FAIL %s snooze_count: got %0d want %0d", tag, snooze_count, m_used);
        end
        n_vec++;
        assert (blink === m_blink) else begin
            n_err++;
            $error("FAIL %s blink: got %b want %b", tag, blink, m_blink);
        end
    endtask

    task automatic cyc(input logic mt, input logic st, input logic sz, input logic sp,
                       input string tag);
        min_tick   = mt;
        sec_tick   = st;
        btn_snooze = sz;
        btn_stop   = sp;
        model_step();
        @(posedge MCLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        alarm_en   = 1'b0;
        cur_time   = 16'h0000;
        alarm_time = 16'h0630;
        min_tick   = 1'b0;
        sec_tick   = 1'b0;
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge MCLK);
        #1;
        check_all("reset_hold");
        reset_n = 1'b1;

        // Arm, non-matching minute, then matching minute.
        alarm_en = 1'b1;
        cur_time = 16'h0629;
        cyc(0, 0, 0, 0, "arm");
        cyc(1, 0, 0, 0, "no_match");
        cur_time = 16'h0630;
        cyc(1, 0, 0, 0, "trigger");
        cyc(0, 0, 0, 0, "ring_hold");

        // Blink toggles on each second while ringing.
        cyc(0, 1, 0, 0, "blink1");
        cyc(0, 1, 0, 0, "blink0");

        // First snooze and its expiry.
        cyc(0, 0, 1, 0, "snooze1");
        cyc(0, 0, 0, 0, "snz_rel");
        cyc(0, 1, 0, 0, "snz_t1");
        cyc(0, 0, 1, 0, "snz_ignored");
        cyc(0, 1, 0, 0, "snz_t2");
        cyc(1, 1, 0, 0, "snz_t3");

        // Second snooze reaches the limit; a third is ignored; auto-stop follows.
        cyc(0, 0, 1, 0, "snooze2");
        cyc(0, 1, 0, 0, "snz2_t1");
        cyc(0, 1, 0, 0, "snz2_t2");
        cyc(0, 1, 0, 0, "snz2_t3");
        cyc(0, 0, 0, 0, "rering");
        cyc(0, 0, 1, 0, "snooze3_ign");
        cyc(0, 1, 1, 0, "auto_t1");
        cyc(0, 1, 0, 0, "auto_t2");
        cyc(0, 1, 0, 0, "auto_t3");
        cyc(0, 1, 0, 0, "auto_stop");

        // Stop beats snooze; a held stop is one event only.
        cyc(1, 0, 0, 0, "retrigger");
        cyc(0, 0, 1, 1, "stop_prio");
        cyc(1, 0, 1, 1, "hold_trig");
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, "stop_held");
        cyc(0, 0, 0, 0, "release");

        // Disable while snoozing.
        cyc(0, 0, 1, 0, "snz_for_dis");
        alarm_en = 1'b0;
        cyc(0, 0, 0, 0, "disable");
        alarm_en = 1'b1;
        cyc(0, 0, 0, 0, "rearm");

        // Asynchronous reset while ringing.
        cyc(1, 0, 0, 0, "trig_for_rst");
        cyc(0, 1, 0, 0, "blink_for_rst");
        reset_n = 1'b0;
        model_reset();
        #2;
        check_all("async_rst");
        @(posedge MCLK);
        #1;
        check_all("rst_held");
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, "post_rst");

        // Randomized traffic around the alarm minute.
        for (int i = 0; i < 400; i++) begin
            alarm_en = ($urandom_range(0, 29) != 0);
            case ($urandom_range(0, 2))
                0:       cur_time = 16'h0629;
                1:       cur_time = 16'h0630;
                default: cur_time = 16'h0631;
            endcase
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
